// File: rtl/noc_scheduler_rob.sv
// Scheduler between a PCI word stream and a NoC mesh, with a reorder buffer that puts results back in tag order.
// Latency: PCI word to NoC flit is 1 cycle; a return for the head tag reaches the PCI output 2 edges after wea.
// Backpressure: o_ready_pci drops while the flit register is stalled or all 2**PCK_W tags are outstanding; wea is always accepted.
//
// Ports:
//   clk, rst                       sole clock (rising edge), asynchronous active-high reset
//   i_valid_pci/i_data_pci/o_ready_pci   PCI words into the scheduler
//   o_valid/o_data/i_ready         tagged flit {data, tag, y, x} toward the NoC
//   wea/i_data_pe                  flits returning from the processing elements (tag selects ROB slot)
//   o_valid_pci/o_data_pci/i_ready_pci   in-order results back to PCI
//   o_outstanding                  tags issued but not yet released into the PCI output register
//   o_err_dup                      sticky flag: a return hit a slot that was already full
module noc_scheduler_rob #(
    parameter int X_NODES       = 2,
    parameter int Y_NODES       = 2,
    parameter int X_W           = 1,
    parameter int Y_W           = 1,
    parameter int PCK_W         = 4,
    parameter int DATA_W        = 32,
    parameter int PKTS_PER_NODE = 8,
    parameter int HOST_X        = 0,
    parameter int HOST_Y        = 0,
    parameter int TOTAL_W       = DATA_W + PCK_W + Y_W + X_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid_pci,
    input  logic [DATA_W-1:0]    i_data_pci,
    output logic                 o_ready_pci,
    output logic                 o_valid_pci,
    output logic [DATA_W-1:0]    o_data_pci,
    input  logic                 i_ready_pci,
    output logic                 o_valid,
    output logic [TOTAL_W-1:0]   o_data,
    input  logic                 i_ready,
    input  logic                 wea,
    input  logic [TOTAL_W-1:0]   i_data_pe,
    output logic [PCK_W:0]       o_outstanding,
    output logic                 o_err_dup
);

    localparam int DEPTH  = 1 << PCK_W;
    localparam int NODE_W = X_W + Y_W;
    localparam int CNT_W  = $clog2(PKTS_PER_NODE + 1);

    localparam logic [X_W-1:0]    X_LAST     = X_W'(X_NODES - 1);
    localparam logic [Y_W-1:0]    Y_LAST     = Y_W'(Y_NODES - 1);
    localparam logic [NODE_W-1:0] HOST_NODE  = {Y_W'(HOST_Y), X_W'(HOST_X)};
    localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(PKTS_PER_NODE - 1);
    localparam logic [PCK_W:0]    CREDITS    = (PCK_W + 1)'(DEPTH);

    // Node coordinates are packed {y, x}, matching the low bits of a flit.
    // Scan order walks y first, then x, wrapping to (0,0) after the last node.
    function automatic logic [NODE_W-1:0] step_node(input logic [NODE_W-1:0] n);
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        x = n[X_W-1:0];
        y = n[NODE_W-1:X_W];
        if (y == Y_LAST) begin
            y = '0;
            x = (x == X_LAST) ? '0 : x + 1'b1;
        end else begin
            y = y + 1'b1;
        end
        return {y, x};
    endfunction

    // One extra step is enough to skip the host because the mesh has at least two nodes.
    function automatic logic [NODE_W-1:0] next_dest(input logic [NODE_W-1:0] n);
        logic [NODE_W-1:0] s;
        s = step_node(n);
        if (s == HOST_NODE) s = step_node(s);
        return s;
    endfunction

    localparam logic [NODE_W-1:0] FIRST_NODE = (HOST_NODE == '0) ? step_node('0) : '0;

    // State
    logic                 out_vld_q, out_vld_d;
    logic [TOTAL_W-1:0]   flit_q, flit_d;
    logic [PCK_W-1:0]     tag_q, tag_d;
    logic [CNT_W-1:0]     burst_q, burst_d;
    logic [NODE_W-1:0]    node_q, node_d;
    logic [PCK_W:0]       outst_q, outst_d;
    logic [PCK_W-1:0]     rd_q, rd_d;
    logic [DEPTH-1:0]     rob_vld_q, rob_vld_d;
    logic                 pci_vld_q, pci_vld_d;
    logic [DATA_W-1:0]    pci_dat_q, pci_dat_d;
    logic                 err_q, err_d;
    logic [DATA_W-1:0]    rob_mem [DEPTH];

    logic                 issue;
    logic                 release_hd;
    logic [PCK_W-1:0]     ret_tag;
    logic [DATA_W-1:0]    ret_dat;
    logic                 ret_new;
    logic                 ret_dup;
    logic                 unused_ret_coords;

    assign ret_tag           = i_data_pe[NODE_W +: PCK_W];
    assign ret_dat           = i_data_pe[TOTAL_W-1 -: DATA_W];
    assign unused_ret_coords = ^i_data_pe[NODE_W-1:0];

    // Ready is held low during reset so nothing is captured before the state is defined.
    assign o_ready_pci = !rst && (!out_vld_q || i_ready) && (outst_q != CREDITS);
    assign issue       = i_valid_pci && o_ready_pci;
    assign release_hd  = (!pci_vld_q || i_ready_pci) && rob_vld_q[rd_q];
    assign ret_new     = wea && !rob_vld_q[ret_tag];
    assign ret_dup     = wea &&  rob_vld_q[ret_tag];

    always_comb begin
        out_vld_d = out_vld_q;
        flit_d    = flit_q;
        tag_d     = tag_q;
        burst_d   = burst_q;
        node_d    = node_q;
        outst_d   = outst_q;
        rd_d      = rd_q;
        rob_vld_d = rob_vld_q;
        pci_vld_d = pci_vld_q;
        pci_dat_d = pci_dat_q;
        err_d     = err_q | ret_dup;

        if (issue) begin
            flit_d    = {i_data_pci, tag_q, node_q};
            out_vld_d = 1'b1;
            tag_d     = tag_q + 1'b1;
            if (burst_q == BURST_LAST) begin
                burst_d = '0;
                node_d  = next_dest(node_q);
            end else begin
                burst_d = burst_q + 1'b1;
            end
        end else if (i_ready) begin
            out_vld_d = 1'b0;
        end

        // A release needs a full slot and a new write needs an empty one,
        // so the two never touch the same valid bit in one cycle.
        if (ret_new) rob_vld_d[ret_tag] = 1'b1;

        if (release_hd) begin
            pci_dat_d          = rob_mem[rd_q];
            pci_vld_d          = 1'b1;
            rob_vld_d[rd_q]    = 1'b0;
            rd_d               = rd_q + 1'b1;
        end else if (i_ready_pci) begin
            pci_vld_d = 1'b0;
        end

        case ({issue, release_hd})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            flit_q    <= '0;
            tag_q     <= '0;
            burst_q   <= '0;
            node_q    <= FIRST_NODE;
            outst_q   <= '0;
            rd_q      <= '0;
            rob_vld_q <= '0;
            pci_vld_q <= 1'b0;
            pci_dat_q <= '0;
            err_q     <= 1'b0;
        end else begin
            out_vld_q <= out_vld_d;
            flit_q    <= flit_d;
            tag_q     <= tag_d;
            burst_q   <= burst_d;
            node_q    <= node_d;
            outst_q   <= outst_d;
            rd_q      <= rd_d;
            rob_vld_q <= rob_vld_d;
            pci_vld_q <= pci_vld_d;
            pci_dat_q <= pci_dat_d;
            err_q     <= err_d;
        end
    end

    // Payload storage: contents are only meaningful under the valid bits, so no reset.
    always_ff @(posedge clk) begin
        if (ret_new) rob_mem[ret_tag] <= ret_dat;
    end

    assign o_valid       = out_vld_q;
    assign o_data        = flit_q;
    assign o_valid_pci   = pci_vld_q;
    assign o_data_pci    = pci_dat_q;
    assign o_outstanding = outst_q;
    assign o_err_dup     = err_q;

endmodule
